// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: both requester ports plus the memory-side signals.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
);
  logic                 P0_Req;
  logic                 P0_Wr;
  logic [AddrWidth-1:0] P0_Addr;
  logic [DataWidth-1:0] P0_DIn;
  logic                 P0_Gnt;
  logic                 P0_Ack;
  logic [DataWidth-1:0] P0_DOut;

  logic                 P1_Req;
  logic                 P1_Wr;
  logic [AddrWidth-1:0] P1_Addr;
  logic [DataWidth-1:0] P1_DIn;
  logic                 P1_Gnt;
  logic                 P1_Ack;
  logic [DataWidth-1:0] P1_DOut;

  logic [AddrWidth-1:0] MEM_Addr;
  logic [DataWidth-1:0] MEM_DIn;
  logic                 MEM_Wr;
  logic                 MEM_En;
  logic [DataWidth-1:0] MEM_DOut;

  logic                 Busy;
  logic                 Owner;

  modport slave (
    input  P0_Req, P0_Wr, P0_Addr, P0_DIn,
    output P0_Gnt, P0_Ack, P0_DOut,
    input  P1_Req, P1_Wr, P1_Addr, P1_DIn,
    output P1_Gnt, P1_Ack, P1_DOut,
    output MEM_Addr, MEM_DIn, MEM_Wr, MEM_En,
    input  MEM_DOut,
    output Busy, Owner
  );

  modport master (
    output P0_Req, P0_Wr, P0_Addr, P0_DIn,
    input  P0_Gnt, P0_Ack, P0_DOut,
    output P1_Req, P1_Wr, P1_Addr, P1_DIn,
    input  P1_Gnt, P1_Ack, P1_DOut,
    input  MEM_Addr, MEM_DIn, MEM_Wr, MEM_En,
    output MEM_DOut,
    input  Busy, Owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory (IDLE/ACCESS/CAPTURE).
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module mem_arbiter #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) (
  input logic          Clk,
  input logic          Reset_N,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                 req0, req1, any_req, win, grant;
  logic                 owner, lat_wr;
  logic                 gnt0, gnt1, ack0, ack1;
  logic [AddrWidth-1:0] lat_addr;
  logic [DataWidth-1:0] lat_din, dout0, dout1;

  // A port's own Ack masks its Req so a requester dropping Req on Ack is not re-served.
  assign req0    = bus.P0_Req & ~ack0;
  assign req1    = bus.P1_Req & ~ack1;
  assign any_req = req0 | req1;
  assign grant   = (state == IDLE) & any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)   last_owner <= 1'b1;
    else if (grant) last_owner <= win;
  end

  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_owner;
  end
`else
  assign win = ~req0;
`endif

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Derived from the async-reset state register, so MEM_En drops the moment reset asserts.
  always_comb begin
    bus.MEM_En = 1'b0;
    bus.MEM_Wr = 1'b0;
    bus.Busy   = 1'b0;
    unique case (state)
      ACCESS: begin
        bus.MEM_En = 1'b1;
        bus.MEM_Wr = lat_wr;
        bus.Busy   = 1'b1;
      end
      CAPTURE: bus.Busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      owner    <= 1'b0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      dout0    <= '0;
      dout1    <= '0;
    end else begin
      gnt0 <= grant & ~win;
      gnt1 <= grant & win;
      ack0 <= (state == CAPTURE) & ~owner;
      ack1 <= (state == CAPTURE) & owner;
      if (grant) begin
        owner    <= win;
        lat_wr   <= win ? bus.P1_Wr   : bus.P0_Wr;
        lat_addr <= win ? bus.P1_Addr : bus.P0_Addr;
        lat_din  <= win ? bus.P1_DIn  : bus.P0_DIn;
      end
      if (state == CAPTURE && !lat_wr) begin
        if (owner) dout1 <= bus.MEM_DOut;
        else       dout0 <= bus.MEM_DOut;
      end
    end
  end

  assign bus.P0_Gnt   = gnt0;
  assign bus.P1_Gnt   = gnt1;
  assign bus.P0_Ack   = ack0;
  assign bus.P1_Ack   = ack1;
  assign bus.P0_DOut  = dout0;
  assign bus.P1_DOut  = dout1;
  assign bus.MEM_Addr = lat_addr;
  assign bus.MEM_DIn  = lat_din;
  assign bus.Owner    = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected transactions in service
// order; a negedge monitor checks each memory access and each Ack against them.
module tb_mem_arbiter;

  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #5 Clk = ~Clk;

  mem_arbiter_if #(.DataWidth(16), .AddrWidth(8)) bus ();

  mem_arbiter #(.DataWidth(16), .AddrWidth(8)) dut (
    .Clk    (Clk),
    .Reset_N(Reset_N),
    .bus    (bus)
  );

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        infl_q[$];
  int          grant_t[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mem_init = 1'b0;
  logic [15:0] mem [256];
  logic [15:0] mdl_dout [2];

  function automatic txn_t mk(input bit p, input bit w, input logic [7:0] a, input logic [15:0] d);
    mk = '{port: p, wr: w, addr: a, data: d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Synchronous single-port memory: read data appears the cycle after the enabled edge.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h05] <= 16'h5555;
      mem[8'h06] <= 16'h6666;
      mem[8'h40] <= 16'h4444;
      mem_init   <= 1'b1;
    end else if (bus.MEM_En) begin
      if (bus.MEM_Wr) mem[bus.MEM_Addr] <= bus.MEM_DIn;
      else            bus.MEM_DOut <= mem[bus.MEM_Addr];
    end
  end

  always @(negedge Clk) begin
    txn_t e;
    if (!Reset_N) begin
      mdl_dout[0] = 16'h0000;
      mdl_dout[1] = 16'h0000;
      infl_q.delete();
      grant_t.delete();
    end else begin
      if (bus.MEM_En) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_access: got owner=%0d addr=%h wr=%0d, expected no access",
                   bus.Owner, bus.MEM_Addr, bus.MEM_Wr);
        end else begin
          e = exp_q.pop_front();
          chk("access", {bus.Owner, bus.MEM_Wr, bus.MEM_Addr, e.wr ? bus.MEM_DIn : 16'h0},
              {e.port, e.wr, e.addr, e.wr ? e.data : 16'h0});
          chk("grant", {bus.P0_Gnt, bus.P1_Gnt, bus.Busy}, {~e.port, e.port, 1'b1});
          infl_q.push_back(e);
          grant_t.push_back(cyc);
        end
      end else begin
        chk("grant_idle", {bus.P0_Gnt, bus.P1_Gnt, bus.MEM_Wr}, 3'b000);
      end
      chk("ack_excl", bus.P0_Ack & bus.P1_Ack, 1'b0);
      if (bus.P0_Ack || bus.P1_Ack) begin
        if (infl_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected none", bus.P0_Ack, bus.P1_Ack);
        end else begin
          e = infl_q.pop_front();
          chk("ack_port", bus.P1_Ack, e.port);
          if (!e.wr) begin
            chk("rd_data", e.port ? bus.P1_DOut : bus.P0_DOut, e.data);
            mdl_dout[e.port] = e.data;
          end
        end
      end
      chk("dout_hold", {bus.P0_DOut, bus.P1_DOut}, {mdl_dout[0], mdl_dout[1]});
    end
  end

  task automatic set_port(input bit p, input bit req, input bit wr, input logic [7:0] a,
                          input logic [15:0] d);
    if (p) begin
      bus.P1_Req = req; bus.P1_Wr = wr; bus.P1_Addr = a; bus.P1_DIn = d;
    end else begin
      bus.P0_Req = req; bus.P0_Wr = wr; bus.P0_Addr = a; bus.P0_DIn = d;
    end
  endtask

  task automatic wait_ack(input bit p, output int k, output bit seen);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge Clk);
      k++;
      seen = p ? bus.P1_Ack : bus.P0_Ack;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: port %0d got no ack, expected ack within 20 cycles", p);
    end
  endtask

  task automatic drive(input bit p, input bit wr, input logic [7:0] a, input logic [15:0] d,
                       input int exp_lat, input bit hold, input bit nowait);
    int  k;
    bit  seen;
    if (!nowait) @(negedge Clk);
    set_port(p, 1'b1, wr, a, d);
    wait_ack(p, k, seen);
    if (seen && exp_lat > 0) chk("ack_latency", k, exp_lat);
    if (hold) begin
      @(posedge Clk);
      #1;
    end
    set_port(p, 1'b0, wr, a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  seen;
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge Clk);
    chk("reset_state", {bus.P0_Gnt, bus.P1_Gnt, bus.P0_Ack, bus.P1_Ack, bus.MEM_En, bus.MEM_Wr,
                        bus.Busy, bus.Owner, bus.MEM_Addr, bus.MEM_DIn, bus.P0_DOut, bus.P1_DOut},
        64'h0);
    Reset_N = 1'b1;

    // Single uncontended read.
    exp_q.push_back(mk(1'b0, 1'b0, 8'h10, 16'hBEEF));
    drive(1'b0, 1'b0, 8'h10, 16'h0000, 3, 1'b0, 1'b0);
    chk("p1_untouched", bus.P1_DOut, 16'h0000);

    // Port 1 write then read back.
    exp_q.push_back(mk(1'b1, 1'b1, 8'h20, 16'h1234));
    drive(1'b1, 1'b1, 8'h20, 16'h1234, 3, 1'b0, 1'b0);
    chk("wr_commit", mem[8'h20], 16'h1234);
    exp_q.push_back(mk(1'b1, 1'b0, 8'h20, 16'h1234));
    drive(1'b1, 1'b0, 8'h20, 16'h0000, 3, 1'b0, 1'b0);

    // Address/data changed during ACCESS must not affect the write in flight.
    exp_q.push_back(mk(1'b0, 1'b1, 8'h05, 16'hA5A5));
    @(negedge Clk);
    set_port(1'b0, 1'b1, 1'b1, 8'h05, 16'hA5A5);
    @(negedge Clk);
    set_port(1'b0, 1'b1, 1'b1, 8'h06, 16'h0F0F);
    wait_ack(1'b0, k, seen);
    set_port(1'b0, 1'b0, 1'b0, 8'h06, 16'h0F0F);
    chk("inflight_addr", mem[8'h05], 16'hA5A5);
    chk("inflight_other", mem[8'h06], 16'h6666);

    // P0 holds Req through its Ack; P1 raised in that Ack cycle wins the next slot.
    exp_q.push_back(mk(1'b0, 1'b0, 8'h10, 16'hBEEF));
    exp_q.push_back(mk(1'b1, 1'b0, 8'h40, 16'h4444));
    fork
      drive(1'b0, 1'b0, 8'h10, 16'h0000, 3, 1'b1, 1'b0);
      begin
        wait_ack(1'b0, k, seen);
        if (seen) drive(1'b1, 1'b0, 8'h40, 16'h0000, 3, 1'b0, 1'b1);
      end
    join
    repeat (4) @(negedge Clk);
    chk("ackmask_drained", exp_q.size(), 0);
    if (grant_t.size() >= 2) chk("ackmask_spacing", grant_t[$] - grant_t[$-1], 3);

    // Both ports requesting out of reset, each re-requesting once.
    @(negedge Clk);
    Reset_N = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h10, 16'hBEEF));
    exp_q.push_back(mk(1'b1, 1'b0, 8'h20, 16'h1234));
    exp_q.push_back(mk(1'b0, 1'b1, 8'h06, 16'h0BAD));
    exp_q.push_back(mk(1'b1, 1'b0, 8'h05, 16'hA5A5));
    fork
      begin
        drive(1'b0, 1'b0, 8'h10, 16'h0000, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h06, 16'h0BAD, 0, 1'b0, 1'b0);
      end
      begin
        drive(1'b1, 1'b0, 8'h20, 16'h0000, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h05, 16'h0000, 0, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(negedge Clk);
        Reset_N = 1'b1;
      end
    join
    chk("contention_grants", grant_t.size(), 4);
    if (grant_t.size() == 4)
      for (int i = 1; i < 4; i++) chk("contention_spacing", grant_t[i] - grant_t[i-1], 3);
    chk("contention_write", mem[8'h06], 16'h0BAD);

    // Fresh contention after a port-0 access: policy decides who goes first.
    exp_q.push_back(mk(1'b0, 1'b0, 8'h05, 16'hA5A5));
    drive(1'b0, 1'b0, 8'h05, 16'h0000, 3, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1'b1, 1'b0, 8'h10, 16'hBEEF));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h20, 16'h1234));
`else
    exp_q.push_back(mk(1'b0, 1'b0, 8'h20, 16'h1234));
    exp_q.push_back(mk(1'b1, 1'b0, 8'h10, 16'hBEEF));
`endif
    fork
      drive(1'b0, 1'b0, 8'h20, 16'h0000, 0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h10, 16'h0000, 0, 1'b0, 1'b0);
    join

    // Asynchronous reset in the ACCESS cycle of a write aborts it.
    exp_q.push_back(mk(1'b0, 1'b1, 8'h30, 16'hAAAA));
    @(negedge Clk);
    set_port(1'b0, 1'b1, 1'b1, 8'h30, 16'hAAAA);
    @(negedge Clk);
    #2 Reset_N = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.P0_Gnt, bus.P1_Gnt, bus.P0_Ack, bus.P1_Ack, bus.MEM_En,
                                bus.MEM_Wr, bus.Busy, bus.Owner, bus.MEM_Addr, bus.MEM_DIn,
                                bus.P0_DOut, bus.P1_DOut}, 64'h0);
    @(posedge Clk);
    #1;
    chk("async_no_commit", mem[8'h30], 16'h0000);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    repeat (6) @(negedge Clk);
    chk("async_still_clean", mem[8'h30], 16'h0000);
    chk("queues_drained", exp_q.size() + infl_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
